// File: rtl/instr_encoder_loader_if.sv
// Request/write-port bundle for instr_encoder_loader: symbolic instruction
// requests in, encoded instruction-memory writes and session status out.
interface instr_encoder_loader_if;
  logic        start;
  logic        inValid;
  logic        inReady;
  logic [3:0]  opSel;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic        imemWrite;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic [10:0] count;
  logic        full;
  logic        badOp;

  modport master (
    output start, inValid, opSel, rs, rt, rd, imm, target,
    input  inReady, imemWrite, imemAddr, imemData, count, full, badOp
  );

  modport slave (
    input  start, inValid, opSel, rs, rt, rd, imm, target,
    output inReady, imemWrite, imemAddr, imemData, count, full, badOp
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs symbolic requests into MIPS words and writes them sequentially to
// instruction memory. Define NOP_PAD_EN to follow j/beq/bneq with a zero word.
module instr_encoder_loader #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_encoder_loader_if.slave  bus
);

`ifdef NOP_PAD_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    WRITE  = 3'd2,
    PAD    = 3'd3,
    FULL   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    WRITE  = 3'd2,
    FULL   = 3'd4
  } state_t;
`endif

  localparam logic [10:0] DEPTH_C = 11'(DEPTH);

  state_t      state_r;
  logic        in_ready_r;
  logic        imem_write_r;
  logic [31:0] imem_addr_r;
  logic [31:0] imem_data_r;
  logic [10:0] count_r;
  logic        full_r;
  logic        bad_op_r;
  logic [10:0] count_inc_s;
`ifdef NOP_PAD_EN
  logic        pad_r;
`endif

  function automatic logic op_legal(input logic [3:0] op_sel);
    return (op_sel <= 4'd11);
  endfunction

`ifdef NOP_PAD_EN
  function automatic logic is_ctrl(input logic [3:0] op_sel);
    return (op_sel == 4'd9) || (op_sel == 4'd10) || (op_sel == 4'd11);
  endfunction
`endif

  function automatic logic [31:0] encode(
    input logic [3:0]  op_sel,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    case (op_sel)
      4'd0:    return {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      4'd1:    return {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      4'd2:    return {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      4'd3:    return {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      4'd4:    return {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      4'd5:    return {6'b001000, rs, rt, imm};
      4'd6:    return {6'b001100, rs, rt, imm};
      4'd7:    return {6'b100011, rs, rt, imm};
      4'd8:    return {6'b101011, rs, rt, imm};
      4'd9:    return {6'b000010, target};
      4'd10:   return {6'b000100, rs, rt, imm};
      4'd11:   return {6'b000101, rs, rt, imm};
      default: return 32'h0000_0000;
    endcase
  endfunction

  assign count_inc_s = count_r + 11'd1;

  // Session FSM with all outputs registered; start overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      in_ready_r   <= 1'b0;
      imem_write_r <= 1'b0;
      imem_addr_r  <= 32'h0000_0000;
      imem_data_r  <= 32'h0000_0000;
      count_r      <= 11'd0;
      full_r       <= 1'b0;
      bad_op_r     <= 1'b0;
`ifdef NOP_PAD_EN
      pad_r        <= 1'b0;
`endif
    end else begin
      bad_op_r <= 1'b0;
      if (bus.start) begin
        // A write in flight still strobes this cycle but is not counted.
        state_r      <= ACCEPT;
        in_ready_r   <= 1'b1;
        imem_write_r <= 1'b0;
        count_r      <= 11'd0;
        full_r       <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            in_ready_r   <= 1'b0;
            imem_write_r <= 1'b0;
          end
          ACCEPT: begin
            if (bus.inValid && op_legal(bus.opSel)) begin
              state_r      <= WRITE;
              in_ready_r   <= 1'b0;
              imem_write_r <= 1'b1;
              imem_addr_r  <= BASE_ADDR + {19'd0, count_r, 2'b00};
              imem_data_r  <= encode(bus.opSel, bus.rs, bus.rt, bus.rd, bus.imm, bus.target);
`ifdef NOP_PAD_EN
              pad_r        <= is_ctrl(bus.opSel);
`endif
            end else if (bus.inValid) begin
              bad_op_r <= 1'b1;
            end else begin
              bad_op_r <= 1'b0;
            end
          end
          WRITE: begin
            count_r      <= count_inc_s;
            imem_write_r <= 1'b0;
            if (count_inc_s == DEPTH_C) begin
              state_r <= FULL;
              full_r  <= 1'b1;
            end
`ifdef NOP_PAD_EN
            else if (pad_r) begin
              state_r      <= PAD;
              pad_r        <= 1'b0;
              imem_write_r <= 1'b1;
              imem_addr_r  <= BASE_ADDR + {19'd0, count_inc_s, 2'b00};
              imem_data_r  <= 32'h0000_0000;
            end
`endif
            else begin
              state_r    <= ACCEPT;
              in_ready_r <= 1'b1;
            end
          end
`ifdef NOP_PAD_EN
          PAD: begin
            count_r      <= count_inc_s;
            imem_write_r <= 1'b0;
            if (count_inc_s == DEPTH_C) begin
              state_r <= FULL;
              full_r  <= 1'b1;
            end else begin
              state_r    <= ACCEPT;
              in_ready_r <= 1'b1;
            end
          end
`endif
          FULL: begin
            in_ready_r   <= 1'b0;
            imem_write_r <= 1'b0;
            full_r       <= 1'b1;
          end
          default: begin
            state_r      <= IDLE;
            in_ready_r   <= 1'b0;
            imem_write_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.inReady   = in_ready_r;
  assign bus.imemWrite = imem_write_r;
  assign bus.imemAddr  = imem_addr_r;
  assign bus.imemData  = imem_data_r;
  assign bus.count     = count_r;
  assign bus.full      = full_r;
  assign bus.badOp     = bad_op_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (DEPTH=4, BASE_ADDR=0); expectations
// follow NOP_PAD_EN when it is defined.
module tb_instr_encoder_loader;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  instr_encoder_loader_if bus ();

  instr_encoder_loader #(
    .DEPTH     (4),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [3:0] op, input logic [4:0] s, input logic [4:0] t,
                     input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg);
    bus.inValid = 1'b1;
    bus.opSel   = op;
    bus.rs      = s;
    bus.rt      = t;
    bus.rd      = d;
    bus.imm     = i;
    bus.target  = tg;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.start = 1'b0; bus.inValid = 1'b0; bus.opSel = 4'd0;
    bus.rs = 5'd0; bus.rt = 5'd0; bus.rd = 5'd0; bus.imm = 16'd0; bus.target = 26'd0;
    tick(); tick();
    chk("rst_inReady", {31'd0, bus.inReady}, 32'd0);
    chk("rst_imemWrite", {31'd0, bus.imemWrite}, 32'd0);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_badOp", {31'd0, bus.badOp}, 32'd0);
    chk("rst_count", {21'd0, bus.count}, 32'd0);
    chk("rst_addr", bus.imemAddr, 32'd0);
    chk("rst_data", bus.imemData, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_inReady", {31'd0, bus.inReady}, 32'd0);

    // Test 1: add r3 = r1 + r2
    pulse_start();
    chk("t1_inReady", {31'd0, bus.inReady}, 32'd1);
    req(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    tick();
    bus.inValid = 1'b0;
    chk("t1_write", {31'd0, bus.imemWrite}, 32'd1);
    chk("t1_addr", bus.imemAddr, 32'h0000_0000);
    chk("t1_data", bus.imemData, 32'h0022_1820);
    chk("t1_ready_in_write", {31'd0, bus.inReady}, 32'd0);
    tick();
    chk("t1_write_done", {31'd0, bus.imemWrite}, 32'd0);
    chk("t1_count", {21'd0, bus.count}, 32'd1);
    chk("t1_data_hold", bus.imemData, 32'h0022_1820);

    // Test 2: addi then lw back to back
    pulse_start();
    chk("t2_count_clr", {21'd0, bus.count}, 32'd0);
    req(4'd5, 5'd0, 5'd5, 5'd0, 16'd7, 26'd0);
    tick();
    req(4'd7, 5'd2, 5'd8, 5'd0, 16'd4, 26'd0);
    chk("t2_addi_data", bus.imemData, 32'h2005_0007);
    chk("t2_addi_addr", bus.imemAddr, 32'h0000_0000);
    chk("t2_ready_w1", {31'd0, bus.inReady}, 32'd0);
    tick();
    chk("t2_gap_write", {31'd0, bus.imemWrite}, 32'd0);
    chk("t2_gap_ready", {31'd0, bus.inReady}, 32'd1);
    tick();
    bus.inValid = 1'b0;
    chk("t2_lw_data", bus.imemData, 32'h8C48_0004);
    chk("t2_lw_addr", bus.imemAddr, 32'h0000_0004);
    chk("t2_ready_w2", {31'd0, bus.inReady}, 32'd0);
    tick();
    chk("t2_count", {21'd0, bus.count}, 32'd2);

    // Test 3: beq then j
    pulse_start();
    req(4'd10, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0);
    tick();
    req(4'd9, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
    chk("t3_beq_data", bus.imemData, 32'h1022_FFFF);
    chk("t3_beq_addr", bus.imemAddr, 32'h0000_0000);
    tick();
`ifdef NOP_PAD_EN
    chk("t3_pad1_write", {31'd0, bus.imemWrite}, 32'd1);
    chk("t3_pad1_addr", bus.imemAddr, 32'h0000_0004);
    chk("t3_pad1_data", bus.imemData, 32'h0000_0000);
    chk("t3_pad1_ready", {31'd0, bus.inReady}, 32'd0);
    tick();
    tick();
    bus.inValid = 1'b0;
    chk("t3_j_data", bus.imemData, 32'h0800_0010);
    chk("t3_j_addr", bus.imemAddr, 32'h0000_0008);
    tick();
    chk("t3_pad2_addr", bus.imemAddr, 32'h0000_000C);
    chk("t3_pad2_data", bus.imemData, 32'h0000_0000);
    tick();
    chk("t3_count", {21'd0, bus.count}, 32'd4);
    chk("t3_full", {31'd0, bus.full}, 32'd1);
`else
    chk("t3_no_pad", {31'd0, bus.imemWrite}, 32'd0);
    tick();
    bus.inValid = 1'b0;
    chk("t3_j_data", bus.imemData, 32'h0800_0010);
    chk("t3_j_addr", bus.imemAddr, 32'h0000_0004);
    tick();
    chk("t3_count", {21'd0, bus.count}, 32'd2);
`endif

    // Test 4: fill to DEPTH=4 with five offered adds
    pulse_start();
    chk("t4_full_clr", {31'd0, bus.full}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      req(4'd0, 5'd1, 5'd2, 5'(i), 16'd0, 26'd0);
      tick();
      chk("t4_write", {31'd0, bus.imemWrite}, 32'd1);
      chk("t4_addr", bus.imemAddr, 32'(4 * i));
      chk("t4_data", bus.imemData, 32'h0022_0020 | (32'(i) << 11));
      tick();
      chk("t4_count", {21'd0, bus.count}, 32'(i + 1));
    end
    tick(); tick();
    chk("t4_full", {31'd0, bus.full}, 32'd1);
    chk("t4_ready", {31'd0, bus.inReady}, 32'd0);
    chk("t4_no_fifth", {31'd0, bus.imemWrite}, 32'd0);
    chk("t4_count_held", {21'd0, bus.count}, 32'd4);
    bus.inValid = 1'b0;
    pulse_start();
    chk("t4_restart_count", {21'd0, bus.count}, 32'd0);
    chk("t4_restart_full", {31'd0, bus.full}, 32'd0);
    req(4'd1, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0);
    tick();
    bus.inValid = 1'b0;
    chk("t4_restart_addr", bus.imemAddr, 32'h0000_0000);
    chk("t4_sub_data", bus.imemData, 32'h0085_3022);
    tick();

    // Test 5: illegal opSel
    req(4'd13, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    tick();
    bus.inValid = 1'b0;
    chk("t5_badOp", {31'd0, bus.badOp}, 32'd1);
    chk("t5_no_write", {31'd0, bus.imemWrite}, 32'd0);
    chk("t5_count", {21'd0, bus.count}, 32'd1);
    chk("t5_ready", {31'd0, bus.inReady}, 32'd1);
    tick();
    chk("t5_badOp_pulse", {31'd0, bus.badOp}, 32'd0);

    // start during WRITE: strobe completes but count is not incremented
    req(4'd3, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    tick();
    bus.inValid = 1'b0;
    chk("ts_write", {31'd0, bus.imemWrite}, 32'd1);
    pulse_start();
    chk("ts_count", {21'd0, bus.count}, 32'd0);
    chk("ts_ready", {31'd0, bus.inReady}, 32'd1);

    // Test 6: reset during WRITE
    req(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    tick();
    bus.inValid = 1'b0;
    chk("t6_pre_write", {31'd0, bus.imemWrite}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_write_drop", {31'd0, bus.imemWrite}, 32'd0);
    chk("t6_count", {21'd0, bus.count}, 32'd0);
    chk("t6_ready", {31'd0, bus.inReady}, 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("t6_idle_ready", {31'd0, bus.inReady}, 32'd0);
    pulse_start();
    chk("t6_after_start", {31'd0, bus.inReady}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Encoder counterpart to the pipeline's opcode decoder. It accepts symbolic instruction requests (operation select plus register and immediate fields) over a valid/ready handshake. Each request is packed into a 32-bit MIPS word using the opcodes and funct codes the controller decodes. Words are written sequentially into instruction memory through a single-cycle write port. Used by testbenches and boot logic to load programs into the pipeline's instruction memory.

Parameters:
DEPTH, 64, maximum number of words written per load session (1..1024)
BASE_ADDR, 32'h0000_0000, byte address of the first word written after start

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a new load session; clears the word count
inValid  input  1  request valid
inReady  output  1  request accepted on this edge when inValid && inReady
opSel  input  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 addi, 6 andi, 7 lw, 8 sw, 9 j, 10 beq, 11 bneq; 12-15 illegal
rs  input  5  source register
rt  input  5  second source / I-type destination
rd  input  5  R-type destination
imm  input  16  I-type immediate / branch offset
target  input  26  jump target field
imemWrite  output  1  instruction-memory write strobe, one cycle per word
imemAddr  output  32  byte address of the write
imemData  output  32  encoded instruction
count  output  11  words written in the current session
full  output  1  count == DEPTH
badOp  output  1  one-cycle pulse: an illegal opSel was accepted

Behaviour:
- Reset (async): state IDLE; inReady, imemWrite, full, badOp = 0; count, imemAddr, imemData = 0.
- States: IDLE, ACCEPT, WRITE, PAD (only with the feature enabled), FULL.
- inReady = 1 only in ACCEPT.
- start has priority over everything except rst. In any state, start for one cycle clears count to 0 and deasserts full. The next state is ACCEPT.
  - If start arrives while in WRITE, that write still completes this cycle, but count does not increment.
- ACCEPT, with inValid high and a legal opSel:
  - The word is encoded and registered, and the state moves to WRITE.
  - In the next cycle, imemWrite=1, imemAddr = BASE_ADDR + 4*count, and imemData holds the word. Latency is 1 cycle from the accept edge to the write strobe.
- ACCEPT, with inValid high and an illegal opSel:
  - badOp pulses in the next cycle. Nothing is written, count is unchanged, and the state stays ACCEPT.
- WRITE:
  - count increments at the end of the cycle.
  - Next state is FULL if the new count == DEPTH, otherwise ACCEPT. Back-to-back accepts therefore occur at most every 2 cycles.
- FULL: full=1 and inReady=0. The block stays there until start or rst.
- Encoding, with shamt always 0:
  - R-type: {6'b000000, rs, rt, rd, 5'b0, funct}, where funct is add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - I-type: {op, rs, rt, imm}, where op is addi 001000, andi 001100, lw 100011, sw 101011, beq 000100, bneq 000101.
  - J-type: {6'b000010, target}.
  - Fields not used by an operation are ignored.
- imemAddr and imemData hold their last values when imemWrite=0.
- Reset mid-write: imemWrite drops immediately (async) and the partial word is discarded.

Optional Feature:
NOP_PAD_EN:
- Defined: after writing j, beq or bneq, the FSM enters PAD and writes 32'h0000_0000 at the next address (imemWrite for one more cycle, count += 1). This provides a hazard slot for the pipeline.
  - PAD is skipped if the branch write made count == DEPTH.
  - inReady stays 0 during PAD.
- Undefined: there is no PAD state, and branches and jumps are written like every other word.

Test Plan:
1. rst, start, add rs=1 rt=2 rd=3 → one cycle after accept: imemWrite=1, imemAddr=0x0, imemData=0x00221820, count→1.
2. addi rs=0 rt=5 imm=7, then lw rs=2 rt=8 imm=4, issued back to back → data 0x20050007 at 0x0, then 0x8C480004 at 0x4; inReady low in each WRITE cycle.
3. beq rs=1 rt=2 imm=0xFFFF, then j target=0x10 → 0x1022FFFF and 0x08000010. With NOP_PAD_EN, each is followed by a 0x00000000 write and count ends at 4.
4. DEPTH=4, offer 5 valid adds → 4 writes at 0x0-0xC, full=1, inReady=0; the fifth is never accepted. start → count=0, next write at 0x0.
5. opSel=13 with inValid → badOp pulses for 1 cycle, no imemWrite, count unchanged, inReady back to 1.
6. Assert rst during a WRITE cycle → imemWrite=0 within the same cycle, count=0, state IDLE, inReady=0 until start.
